// File: rtl/fsm_clock_top.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// fsm_clock_top : hh:mm:ss time-of-day counter built from cascaded field FSMs.
// Optional DAY_TICK_EN macro adds a registered one-cycle day_tick output.
// Revision 1.0
// ============================================================================

module fsm_clock_field #(
  parameter int MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] load_val,
  input  logic       carry_in,
  output logic [5:0] value,
  output logic       carry_out
);

  localparam logic [5:0] C_MAX = 6'(MAX);

  logic [5:0] value_d;
  logic [5:0] value_q;

  // Out-of-range presets collapse to zero so the field never exceeds MAX.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (load_val > C_MAX) ? 6'd0 : load_val;
    end else if (carry_in) begin
      value_d = (value_q == C_MAX) ? 6'd0 : value_q + 6'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= 6'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value     = value_q;
  assign carry_out = carry_in && (value_q == C_MAX);

endmodule

module fsm_clock_top #(
  parameter int TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_in,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  input  logic [5:0] hour_in,
  output logic [5:0] sec_out,
  output logic [5:0] min_out,
  output logic [5:0] hour_out
`ifdef DAY_TICK_EN
  ,
  output logic       day_tick
`endif
);

  localparam int C_DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } ctrl_t;

  ctrl_t state_d;
  ctrl_t state_q;

  logic [C_DIV_W-1:0] div_d;
  logic [C_DIV_W-1:0] div_q;

  logic run_en;
  logic tick;
  logic sec_carry;
  logic min_carry;
  logic hour_wrap;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = load_in ? ST_LOAD : ST_RUN;
      ST_LOAD: state_d = load_in ? ST_LOAD : ST_RUN;
      ST_RUN:  state_d = load_in ? ST_LOAD : ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Counting is enabled on the edge that enters RUN, so the first advance
  // lands exactly TICK_DIV edges after load_in is released.
  assign run_en = (state_d == ST_RUN);
  assign tick   = run_en && (div_q == C_DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (!run_en || tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + C_DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
    end
  end

  fsm_clock_field #(.MAX(59)) u_sec (
    .clk       (clk),
    .rst       (rst),
    .load      (load_in),
    .load_val  (sec_in),
    .carry_in  (tick),
    .value     (sec_out),
    .carry_out (sec_carry)
  );

  fsm_clock_field #(.MAX(59)) u_min (
    .clk       (clk),
    .rst       (rst),
    .load      (load_in),
    .load_val  (min_in),
    .carry_in  (sec_carry),
    .value     (min_out),
    .carry_out (min_carry)
  );

  fsm_clock_field #(.MAX(23)) u_hour (
    .clk       (clk),
    .rst       (rst),
    .load      (load_in),
    .load_val  (hour_in),
    .carry_in  (min_carry),
    .value     (hour_out),
    .carry_out (hour_wrap)
  );

`ifdef DAY_TICK_EN
  logic day_tick_d;
  logic day_tick_q;

  // hour_wrap only fires from a counting carry; a preset never raises it.
  always_comb begin
    day_tick_d = hour_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      day_tick_q <= 1'b0;
    end else begin
      day_tick_q <= day_tick_d;
    end
  end

  assign day_tick = day_tick_q;
`else
  logic unused_hour_wrap;
  assign unused_hour_wrap = hour_wrap;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fsm_clock_top.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for fsm_clock_top: two instances (TICK_DIV 1 and 4) on shared stimulus,
// scored against a seconds-of-day reference model through per-DUT queues.
module tb_fsm_clock_top;

  localparam int TD_A = 1;
  localparam int TD_B = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_in = 1'b0;
  logic [5:0] sec_in = 6'd0;
  logic [5:0] min_in = 6'd0;
  logic [5:0] hour_in = 6'd0;

  logic [5:0] sec_a, min_a, hour_a;
  logic [5:0] sec_b, min_b, hour_b;
  logic       day_a, day_b;

`ifdef DAY_TICK_EN
  fsm_clock_top #(.TICK_DIV(TD_A)) dut_a (
    .clk(clk), .rst(rst), .load_in(load_in),
    .sec_in(sec_in), .min_in(min_in), .hour_in(hour_in),
    .sec_out(sec_a), .min_out(min_a), .hour_out(hour_a), .day_tick(day_a)
  );
  fsm_clock_top #(.TICK_DIV(TD_B)) dut_b (
    .clk(clk), .rst(rst), .load_in(load_in),
    .sec_in(sec_in), .min_in(min_in), .hour_in(hour_in),
    .sec_out(sec_b), .min_out(min_b), .hour_out(hour_b), .day_tick(day_b)
  );
`else
  fsm_clock_top #(.TICK_DIV(TD_A)) dut_a (
    .clk(clk), .rst(rst), .load_in(load_in),
    .sec_in(sec_in), .min_in(min_in), .hour_in(hour_in),
    .sec_out(sec_a), .min_out(min_a), .hour_out(hour_a)
  );
  fsm_clock_top #(.TICK_DIV(TD_B)) dut_b (
    .clk(clk), .rst(rst), .load_in(load_in),
    .sec_in(sec_in), .min_in(min_in), .hour_in(hour_in),
    .sec_out(sec_b), .min_out(min_b), .hour_out(hour_b)
  );
  assign day_a = 1'b0;
  assign day_b = 1'b0;
`endif

  always #10 clk = ~clk;

  // Reference model: time of day as a plain count of seconds since midnight.
  int          m_t[2];
  int          m_cnt[2];
  bit          m_day[2];
  int          td[2];
  logic [18:0] q0[$];
  logic [18:0] q1[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [18:0] model_out(input int i);
    return {m_day[i], 6'(m_t[i] / 3600), 6'((m_t[i] / 60) % 60), 6'(m_t[i] % 60)};
  endfunction

  function automatic logic [18:0] actual(input int i);
    logic [18:0] v;
    if (i == 0) v = {day_a, hour_a, min_a, sec_a};
    else        v = {day_b, hour_b, min_b, sec_b};
    return v;
  endfunction

  function automatic void check(input string name, input logic [18:0] exp, input logic [18:0] act);
    logic [18:0] e;
    e = exp;
`ifndef DAY_TICK_EN
    e[18] = 1'b0;
`endif
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got day=%0b %0d:%0d:%0d expected day=%0b %0d:%0d:%0d",
               name, act[18], act[17:12], act[11:6], act[5:0],
               e[18], e[17:12], e[11:6], e[5:0]);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_t[i] = 0; m_cnt[i] = 0; m_day[i] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    int s, m, h;
    for (int i = 0; i < 2; i++) begin
      m_day[i] = 1'b0;
      if (rst) begin
        m_t[i] = 0; m_cnt[i] = 0;
      end else if (load_in) begin
        s = (sec_in > 59) ? 0 : int'(sec_in);
        m = (min_in > 59) ? 0 : int'(min_in);
        h = (hour_in > 23) ? 0 : int'(hour_in);
        m_t[i] = h * 3600 + m * 60 + s;
        m_cnt[i] = 0;
      end else begin
        m_cnt[i]++;
        if (m_cnt[i] == td[i]) begin
          m_cnt[i] = 0;
          if (m_t[i] == 86399) m_day[i] = 1'b1;
          m_t[i] = (m_t[i] + 1) % 86400;
        end
      end
    end
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
  endfunction

  // Monitor: outputs are registered, so every negedge presents a result.
  always @(negedge clk) begin
    if (q0.size() > 0) check("td1_state", q0.pop_front(), actual(0));
    if (q1.size() > 0) check("td4_state", q1.pop_front(), actual(1));
  end

  task automatic cycle(input logic r, input logic ld, input logic [5:0] s,
                       input logic [5:0] m, input logic [5:0] h);
    @(negedge clk);
    rst = r; load_in = ld; sec_in = s; min_in = m; hour_in = h;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic async_reset();
    @(negedge clk);
    #5;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_clear_td1", model_out(0), actual(0));
    check("async_clear_td4", model_out(1), actual(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int r;
    td[0] = TD_A;
    td[1] = TD_B;
    model_reset();
    load_in = 1'b1; sec_in = 6'd33; min_in = 6'd14; hour_in = 6'd5;
    #2 rst = 1'b1;
    #1;
    check("reset_td1", model_out(0), actual(0));
    check("reset_td4", model_out(1), actual(1));

    repeat (4) cycle(1'b1, 1'b1, 6'd33, 6'd14, 6'd5);
    repeat (3) cycle(1'b0, 1'b1, 6'd33, 6'd14, 6'd5);
    repeat (90) cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0);

    cycle(1'b0, 1'b1, 6'd59, 6'd59, 6'd23);
    repeat (6) cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0);

    cycle(1'b0, 1'b1, 6'd60, 6'd7, 6'd30);
    repeat (3) cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0);

    repeat (10) cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0);
    async_reset();
    repeat (2) cycle(1'b1, 1'b0, 6'd0, 6'd0, 6'd0);
    repeat (9) cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        async_reset();
        cycle(1'b1, 1'b1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
      end else if (r < 10) begin
        cycle(1'b0, 1'b1, 6'($urandom_range(50, 59)), 6'd59, 6'd23);
      end else if (r < 18) begin
        cycle(1'b0, 1'b1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
      end else begin
        cycle(1'b0, 1'b0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
      end
    end

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
